// File: rtl/hdb3_enc.sv
// HDB3 line encoder: NRZ bit stream in, dual-rail pulse pair out.
// Four-slot look-ahead lets a B pulse be placed retroactively on the first zero of a run.
module hdb3_enc (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic hdb3_p,
  output logic hdb3_n,
  output logic v_flag,
  output logic b_flag
);

  typedef enum logic [1:0] {
    SlotEmpty = 2'b00,
    SlotMark  = 2'b01,
    SlotBpul  = 2'b10,
    SlotVpul  = 2'b11
  } slot_e;

  // slot0 is the newest entry, slot3 the oldest and the one driving the output stage
  slot_e      slot0_q, slot1_q, slot2_q, slot3_q;
  slot_e      slot0_d, slot1_d, slot2_d, slot3_d;
  logic [1:0] zero_cnt_q, zero_cnt_d;
  logic       parity_q, parity_d;
  // 1 = last pulse positive, 0 = negative
  logic       last_pol_q, last_pol_d;
  logic       hdb3_p_q, hdb3_p_d;
  logic       hdb3_n_q, hdb3_n_d;
  logic       v_flag_q, v_flag_d;
  logic       b_flag_q, b_flag_d;

  // Input stage: classify the incoming bit and detect the fourth consecutive zero.
  always_comb begin
    slot0_d    = SlotEmpty;
    slot1_d    = slot0_q;
    slot2_d    = slot1_q;
    slot3_d    = slot2_q;
    zero_cnt_d = zero_cnt_q;
    parity_d   = parity_q;

    if (data_in) begin
      slot0_d    = SlotMark;
      zero_cnt_d = 2'd0;
      parity_d   = ~parity_q;
    end else if (zero_cnt_q != 2'd3) begin
      zero_cnt_d = zero_cnt_q + 2'd1;
    end else begin
      slot0_d    = SlotVpul;
      zero_cnt_d = 2'd0;
      parity_d   = 1'b0;
      // Even mark count since the last V needs a B so consecutive Vs alternate
      if (!parity_q) begin
        slot3_d = SlotBpul;
      end
    end
  end

  // Polarity stage: turn the oldest slot into rail pulses.
  always_comb begin
    last_pol_d = last_pol_q;
    hdb3_p_d   = 1'b0;
    hdb3_n_d   = 1'b0;
    v_flag_d   = 1'b0;
    b_flag_d   = 1'b0;

    unique case (slot3_q)
      SlotMark, SlotBpul: begin
        last_pol_d = ~last_pol_q;
        hdb3_p_d   = ~last_pol_q;
        hdb3_n_d   = last_pol_q;
        b_flag_d   = (slot3_q == SlotBpul);
      end
      SlotVpul: begin
        // Violation repeats the previous polarity
        hdb3_p_d = last_pol_q;
        hdb3_n_d = ~last_pol_q;
        v_flag_d = 1'b1;
      end
      default: begin
        hdb3_p_d = 1'b0;
        hdb3_n_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q    <= SlotEmpty;
      slot1_q    <= SlotEmpty;
      slot2_q    <= SlotEmpty;
      slot3_q    <= SlotEmpty;
      zero_cnt_q <= 2'd0;
      parity_q   <= 1'b0;
      last_pol_q <= 1'b0;
      hdb3_p_q   <= 1'b0;
      hdb3_n_q   <= 1'b0;
      v_flag_q   <= 1'b0;
      b_flag_q   <= 1'b0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      slot2_q    <= slot2_d;
      slot3_q    <= slot3_d;
      zero_cnt_q <= zero_cnt_d;
      parity_q   <= parity_d;
      last_pol_q <= last_pol_d;
      hdb3_p_q   <= hdb3_p_d;
      hdb3_n_q   <= hdb3_n_d;
      v_flag_q   <= v_flag_d;
      b_flag_q   <= b_flag_d;
    end
  end

  assign hdb3_p = hdb3_p_q;
  assign hdb3_n = hdb3_n_q;
  assign v_flag = v_flag_q;
  assign b_flag = b_flag_q;

endmodule

// File: tb/tb_hdb3_enc.sv
// Bench for hdb3_enc: hand-written pulse patterns plus random streams against a sequence model.
module tb_hdb3_enc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic data_in = 1'b0;
  logic hdb3_p, hdb3_n, v_flag, b_flag;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: symbol per input bit (0 zero, 1 mark, 2 B, 3 V), rewritten as runs complete
  int sym[$];
  int m_zeros;
  int m_ones;
  int m_pol;  // 1 = last pulse positive

  hdb3_enc dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_in(data_in),
    .hdb3_p (hdb3_p),
    .hdb3_n (hdb3_n),
    .v_flag (v_flag),
    .b_flag (b_flag)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got {p,n,v,b}=%b, want %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {hdb3_p, hdb3_n, v_flag, b_flag};
  endfunction

  task automatic model_clear();
    sym.delete();
    m_zeros = 0;
    m_ones  = 0;
    m_pol   = 0;
  endtask

  // Append one input bit; a fourth zero turns the run into 000V or B00V
  task automatic model_push(input logic b);
    if (b) begin
      sym.push_back(1);
      m_zeros = 0;
      m_ones++;
    end else begin
      sym.push_back(0);
      m_zeros++;
      if (m_zeros == 4) begin
        sym[sym.size()-1] = 3;
        if (m_ones % 2 == 0) sym[sym.size()-4] = 2;
        m_zeros = 0;
        m_ones  = 0;
      end
    end
  endtask

  // Expected outputs after edge e; must be called once per edge in order
  function automatic logic [3:0] model_out(input int e);
    int s;
    if (e < 4) return 4'b0000;
    s = sym[e-4];
    if (s == 0) return 4'b0000;
    if (s == 3) return {m_pol[0], ~m_pol[0], 2'b10};
    m_pol = 1 - m_pol;
    return {m_pol[0], ~m_pol[0], 1'b0, (s == 2)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    data_in = 1'b0;
    #1;
    check_out("reset_outputs", outs(), 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Pattern chars: 0 none, + / - mark, B / b B pulse, V / v V pulse (upper = positive)
  function automatic logic [3:0] decode(input byte c);
    case (c)
      "+": return 4'b1000;
      "-": return 4'b0100;
      "B": return 4'b1001;
      "b": return 4'b0101;
      "V": return 4'b1010;
      "v": return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic run_pattern(input string name, input string din, input string dexp);
    do_reset();
    for (int t = 0; t < din.len() + 4; t++) begin
      data_in = (t < din.len()) ? (din[t] == "1") : 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (t < 4) check_out($sformatf("%s_fill%0d", name, t), outs(), 4'b0000);
      else       check_out($sformatf("%s_pos%0d", name, t - 4), outs(), decode(dexp[t-4]));
    end
  endtask

  task automatic run_random(input int cycles, input int reset_at);
    logic b;
    int e;
    do_reset();
    e = 0;
    for (int t = 0; t < cycles; t++) begin
      if (t == reset_at) begin
        do_reset();
        e = 0;
      end
      // Zero-heavy so four-zero runs and both substitution forms are frequent
      b = ($urandom_range(0, 2) == 0);
      data_in = b;
      model_push(b);
      @(posedge clk);
      @(negedge clk);
      check_out($sformatf("rand_e%0d", e), outs(), model_out(e));
      if (hdb3_p && hdb3_n) check_out("rails_exclusive", 4'b1100, 4'b0000);
      e++;
    end
  endtask

  initial begin
    model_clear();
    run_pattern("ones",      "1111111",      "+-+-+-+");
    run_pattern("z4_then1",  "00001",        "B00V-");
    run_pattern("odd_000v",  "100001",       "+000V-");
    run_pattern("even_b00v", "110000",       "+-B00V");
    run_pattern("z12",       "000000000000", "B00Vb00vB00V");
    run_pattern("mixed",     "10100001",     "+0-B00V-");
    run_random(3000, 1500);
    run_random(2000, 777);
    run_pattern("resume_z4", "00001",        "B00V-");
    run_pattern("resume_z12", "000000000000", "B00Vb00vB00V");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
